// File: rtl/hazard_stall_if.sv
// Hazard/stall control bundle between the pipeline hazard logic and the stall controller.
interface hazard_stall_if;
  logic        fetch_nop_LD;
  logic        call_or_branch;
  logic        branch_taken;
  logic        pc_write_en;
  logic        ifid_write_en;
  logic        idex_bubble;
  logic        ifid_flush;
  logic        stall_active;
  logic [15:0] stall_cycles;

  modport master (
    output fetch_nop_LD, call_or_branch, branch_taken,
    input  pc_write_en, ifid_write_en, idex_bubble, ifid_flush, stall_active, stall_cycles
  );

  modport slave (
    input  fetch_nop_LD, call_or_branch, branch_taken,
    output pc_write_en, ifid_write_en, idex_bubble, ifid_flush, stall_active, stall_cycles
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller: one bubble per load-use hazard, bounded hold for
// call/branch hazards, redirect flush from EX overriding everything.
module hazard_stall_ctrl #(
  parameter int unsigned MAX_BR_STALL = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  hazard_stall_if.slave  hz
);

  typedef enum logic [1:0] {IDLE, LU_MASK, BR_HOLD} state_t;
  typedef enum logic [1:0] {M_NORMAL, M_STALL, M_FLUSH} mode_t;

  localparam logic [2:0] BR_MAX = 3'(MAX_BR_STALL);

  state_t      state, state_nxt;
  logic [2:0]  br_cnt, br_cnt_nxt;
  mode_t       mode;
  logic        stall_active_q;
  logic [15:0] stall_cycles_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      br_cnt <= 3'd0;
    end else begin
      state  <= state_nxt;
      br_cnt <= br_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    br_cnt_nxt = br_cnt;
    mode       = M_NORMAL;
    if (hz.branch_taken) begin
      mode       = M_FLUSH;
      state_nxt  = IDLE;
      br_cnt_nxt = 3'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hz.fetch_nop_LD) begin
            mode = M_STALL;
            if (hz.call_or_branch) begin
              state_nxt  = BR_HOLD;
              br_cnt_nxt = 3'd1;
            end else begin
              state_nxt  = LU_MASK;
              br_cnt_nxt = 3'd0;
            end
          end
        end
        // The load-use request is still visible for one cycle after its bubble; swallow it.
        LU_MASK: begin
          state_nxt  = IDLE;
          br_cnt_nxt = 3'd0;
        end
        BR_HOLD: begin
          if (hz.fetch_nop_LD && (br_cnt < BR_MAX)) begin
            mode       = M_STALL;
            br_cnt_nxt = br_cnt + 3'd1;
          end else if (hz.fetch_nop_LD) begin
            // Hold budget exhausted: let the pipe advance once, then mask the stale request.
            state_nxt  = LU_MASK;
            br_cnt_nxt = 3'd0;
          end else begin
            state_nxt  = IDLE;
            br_cnt_nxt = 3'd0;
          end
        end
        default: begin
          state_nxt  = IDLE;
          br_cnt_nxt = 3'd0;
        end
      endcase
    end
  end

  always_comb begin
    hz.pc_write_en   = 1'b1;
    hz.ifid_write_en = 1'b1;
    hz.idex_bubble   = 1'b0;
    hz.ifid_flush    = 1'b0;
    if (!rst_n) begin
      hz.pc_write_en   = 1'b0;
      hz.ifid_write_en = 1'b0;
      hz.idex_bubble   = 1'b1;
    end else begin
      unique case (mode)
        M_STALL: begin
          hz.pc_write_en   = 1'b0;
          hz.ifid_write_en = 1'b0;
          hz.idex_bubble   = 1'b1;
        end
        M_FLUSH: begin
          hz.idex_bubble = 1'b1;
          hz.ifid_flush  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Registered copy of (state != IDLE); loaded from the same next-state as the state flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_active_q <= 1'b0;
      stall_cycles_q <= 16'd0;
    end else begin
      stall_active_q <= (state_nxt != IDLE);
      if (!hz.pc_write_en && (stall_cycles_q != 16'hFFFF))
        stall_cycles_q <= stall_cycles_q + 16'd1;
    end
  end

  assign hz.stall_active = stall_active_q;
  assign hz.stall_cycles = stall_cycles_q;

endmodule
